// File: rtl/dpram_pkg.sv
// Shared types and helpers for the dual-port buffer bank.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state type, default widths, byte-lane merge helper.
package dpram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // The merge helper works on a fixed wide word so one function serves every
  // DATA_W; callers zero-extend their operands and take the low DATA_W bits.
  localparam int MERGE_W    = 1024;
  localparam int MERGE_BE_W = MERGE_W / 8;

  // Byte i of the result comes from new_w when be[i] is set, else from old_w.
  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]    old_w,
    input logic [MERGE_W-1:0]    new_w,
    input logic [MERGE_BE_W-1:0] be
  );
    logic [MERGE_W-1:0] r;
    for (int i = 0; i < MERGE_BE_W; i++) begin
      r[i*8 +: 8] = be[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dpram_bank_ctrl_if.sv
// Access bus of the buffer bank: one byte-enabled write port, one read port.
// Latency: n/a (bundle of wires).
// Backpressure: none on the bus itself; ready tells the master when accesses count.
// master: drives clear_req/wen/waddr/wbe/d_in/ren/raddr, sees ready/d_out/rvalid.
// slave : the bank side of the same signals.
interface dpram_bank_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int BE_W = DATA_W / 8;

  logic              clear_req;
  logic              ready;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [BE_W-1:0]   wbe;
  logic [DATA_W-1:0] d_in;
  logic              ren;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] d_out;
  logic              rvalid;

  modport master (
    output clear_req, wen, waddr, wbe, d_in, ren, raddr,
    input  ready, d_out, rvalid
  );

  modport slave (
    input  clear_req, wen, waddr, wbe, d_in, ren, raddr,
    output ready, d_out, rvalid
  );
endinterface

// File: rtl/dpram_bank_array.sv
// Plain storage array: byte-enabled synchronous write, registered read.
// Latency: rdata updates one edge after re; a same-edge write is not visible (read-old).
// Backpressure: none; caller guarantees in-range indices.
// Ports: clk, we/waddr/wbe/wdata write side, re/raddr/rdata read side.
module dpram_bank_array
  import dpram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= DATA_W'(byte_merge(MERGE_W'(mem[waddr]), MERGE_W'(wdata),
                                       MERGE_BE_W'(wbe)));
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dpram_bank_ctrl.sv
// Generic on-chip buffer bank: clear engine, range checks, write-first bypass.
// Latency: read data 1 cycle after ren (2 with DPRAM_BANK_READ_PIPE_EN); clear takes DEPTH cycles.
// Backpressure: none; accesses while ready=0 or alongside clear_req are dropped.
// Ports: clk, rst (async, active high), bus (slave modport of dpram_bank_ctrl_if).
// Option macro: DPRAM_BANK_READ_PIPE_EN adds an output register stage.
module dpram_bank_ctrl
  import dpram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 32
) (
  input logic              clk,
  input logic              rst,
  dpram_bank_ctrl_if.slave bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              ready_q;

  // clear_req wins over any access issued in the same cycle.
  logic accept, wr_ok, rd_acc, rd_in, collide;
  assign accept  = ready_q & ~bus.clear_req;
  assign wr_ok   = bus.wen & accept & ({1'b0, bus.waddr} < LIMIT);
  assign rd_acc  = bus.ren & accept;
  assign rd_in   = rd_acc & ({1'b0, bus.raddr} < LIMIT);
  assign collide = rd_in & wr_ok & (bus.raddr == bus.waddr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_cnt == LAST) begin
            state   <= RUN;
            ready_q <= 1'b1;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        RUN: begin
          if (bus.clear_req) begin
            state   <= CLEAR;
            ready_q <= 1'b0;
            clr_cnt <= '0;
          end
        end
        default: begin
          state   <= CLEAR;
          ready_q <= 1'b0;
          clr_cnt <= '0;
        end
      endcase
    end
  end

  // Clear engine owns the write port while in CLEAR.
  logic              arr_we;
  logic [IDX_W-1:0]  arr_waddr;
  logic [BE_W-1:0]   arr_wbe;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = clr_cnt[IDX_W-1:0];
    arr_wbe   = '1;
    arr_wdata = '0;
    if (state == CLEAR) begin
      arr_we = 1'b1;
    end else if (wr_ok) begin
      arr_we    = 1'b1;
      arr_waddr = bus.waddr[IDX_W-1:0];
      arr_wbe   = bus.wbe;
      arr_wdata = bus.d_in;
    end
  end

  dpram_bank_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wbe   (arr_wbe),
    .wdata (arr_wdata),
    .re    (rd_in),
    .raddr (bus.raddr[IDX_W-1:0]),
    .rdata (arr_rdata)
  );

  // Side information registered alongside the array read. The array returns
  // the pre-write word, so a colliding write's lanes are patched in here.
  // out_zero covers reset and out-of-range reads without resetting the array.
  logic              rvalid_s1;
  logic              out_zero;
  logic [BE_W-1:0]   byp_be;
  logic [DATA_W-1:0] byp_dat;
  logic [DATA_W-1:0] rd_dat_s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_s1 <= 1'b0;
      out_zero  <= 1'b1;
      byp_be    <= '0;
      byp_dat   <= '0;
    end else begin
      rvalid_s1 <= rd_acc;
      if (rd_acc) begin
        out_zero <= ~rd_in;
        byp_be   <= collide ? bus.wbe : '0;
        byp_dat  <= bus.d_in;
      end
    end
  end

  assign rd_dat_s1 = out_zero ? '0 :
                     DATA_W'(byte_merge(MERGE_W'(arr_rdata), MERGE_W'(byp_dat),
                                        MERGE_BE_W'(byp_be)));

  assign bus.ready = ready_q;

`ifdef DPRAM_BANK_READ_PIPE_EN
  // Output stage; a read still in flight when a clear starts is discarded.
  logic              flush;
  logic              pipe_vld;
  logic [DATA_W-1:0] pipe_dat;

  assign flush = (state == CLEAR) | bus.clear_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= 1'b0;
      pipe_dat <= '0;
    end else begin
      pipe_vld <= rvalid_s1 & ~flush;
      if (rvalid_s1 & ~flush) begin
        pipe_dat <= rd_dat_s1;
      end
    end
  end

  assign bus.rvalid = pipe_vld;
  assign bus.d_out  = pipe_dat;
`else
  assign bus.rvalid = rvalid_s1;
  assign bus.d_out  = rd_dat_s1;
`endif

endmodule
